// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared CPU opcodes (ILW/ISW/IROP/IJ) and memory sizing defaults
package data_memory_pkg;
  localparam logic [5:0] IROP = 6'b000000;
  localparam logic [5:0] IJ   = 6'b000010;
  localparam logic [5:0] ILW  = 6'b100011;
  localparam logic [5:0] ISW  = 6'b101011;
  localparam int DM_ADDR_WIDTH = 8;
  localparam int DM_DATA_WIDTH = 32;
  function automatic logic is_load(input logic [5:0] op);
    return op == ILW;
  endfunction
  function automatic logic is_store(input logic [5:0] op);
    return op == ISW;
  endfunction
endpackage

// File: rtl/data_memory_ram.sv
// data_memory_ram: word RAM, sync write on clk, async read, async clear (clk, clr, we, addr, wdata -> rdata)
module data_memory_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  always_ff @(posedge clk or posedge clr) begin
    if (clr) mem_q <= '{default: '0};
    else if (we) mem_q[addr] <= wdata;
  end
  assign rdata = mem_q[addr];
endmodule

// File: rtl/data_memory.sv
// data_memory: M-stage word memory (clk, reset, M_op, M_valE index, M_valA store data -> m_valM load data)
module data_memory
  import data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = DM_ADDR_WIDTH,
  parameter int DATA_WIDTH = DM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            M_op,
  input  logic [31:0]           M_valE,
  input  logic [DATA_WIDTH-1:0] M_valA,
  output logic [DATA_WIDTH-1:0] m_valM
);
  logic [DATA_WIDTH-1:0] rdata;
  logic unused_hi;
  assign unused_hi = ^M_valE[31:ADDR_WIDTH];
  data_memory_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram (
    .clk(clk),
    .clr(reset),
    .we(is_store(M_op) && !reset),
    .addr(M_valE[ADDR_WIDTH-1:0]),
    .wdata(M_valA),
    .rdata(rdata)
  );
  assign m_valM = (is_load(M_op) && !reset) ? rdata : '0;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed self-checking bench for data_memory
module tb_data_memory;
  import data_memory_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] M_op = ILW;
  logic [31:0] M_valE = '0;
  logic [31:0] M_valA = '0;
  logic [31:0] m_valM;
  int checks = 0;
  int errors = 0;
  data_memory dut (
    .clk(clk),
    .reset(reset),
    .M_op(M_op),
    .M_valE(M_valE),
    .M_valA(M_valA),
    .m_valM(m_valM)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] exp);
    #1;
    checks++;
    assert (m_valM === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, m_valM, exp);
    end
  endtask
  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    M_op = op;
    M_valE = a;
    M_valA = d;
  endtask
  task automatic edge_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    #12 reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drive(ILW, i, 32'h0);
      chk($sformatf("reset_rd%0d", i), 32'h0);
    end
    drive(ISW, 1, 1);
    chk("store_reads0", 32'h0);
    edge_cycle();
    drive(ISW, 2, 2);
    edge_cycle();
    drive(ILW, 2, 0);
    chk("ld2", 32'h2);
    drive(ILW, 1, 0);
    chk("ld1", 32'h1);
    drive(IROP, 3, 3);
    chk("irop_rd", 32'h0);
    edge_cycle();
    drive(ILW, 3, 0);
    chk("irop_nowrite", 32'h0);
    drive(IJ, 3, 3);
    chk("ij_rd", 32'h0);
    drive(6'b111111, 1, 0);
    chk("unk_rd", 32'h0);
    drive(ISW, 257, 32'hDEADBEEF);
    edge_cycle();
    drive(ILW, 1, 0);
    chk("alias_ld1", 32'hDEADBEEF);
    drive(ILW, 257, 0);
    chk("alias_ld257", 32'hDEADBEEF);
    drive(ISW, 5, 32'h1234);
    edge_cycle();
    drive(ILW, 5, 0);
    chk("ld5", 32'h1234);
    reset = 1'b1;
    chk("async_rst_ld5", 32'h0);
    drive(ISW, 5, 32'h5555);
    edge_cycle();
    drive(ILW, 5, 0);
    chk("rst_wins_store", 32'h0);
    reset = 1'b0;
    chk("post_rst_ld5", 32'h0);
    drive(ILW, 2, 0);
    chk("post_rst_ld2", 32'h0);
    drive(ISW, 6, 32'hA5A5_0F0F);
    edge_cycle();
    drive(ILW, 6, 0);
    chk("post_rst_write", 32'hA5A5_0F0F);
    drive(ILW, 255, 0);
    chk("ld_top_word", 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
